// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg                                                      |
// | Shared defaults, FSM encodings and round-robin pick for the memory   |
// | arbiter, its interface and the blocks that connect to it.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  // Encodings 2 and 3 are unused; the FSM treats them as S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1
  } arb_state_t;

  // Round-robin pick: a lone requester wins; on contention the port that
  // was not granted last time wins.
  function automatic logic rr_pick(input logic cs0, input logic cs1, input logic last);
    logic pick;
    if (cs0 && cs1) pick = ~last;
    else            pick = cs1;
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if                                                       |
// | Bundles both requester handshakes and the RAM handshake. The slave   |
// | modport is the arbiter's view; master is the environment's view      |
// | (requesters plus RAM).                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Requester port 0
  logic              c0_cs;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_din;
  logic [DATA_W-1:0] c0_dout;
  logic              c0_ack;
  logic              c0_stall;

  // Requester port 1
  logic              c1_cs;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_din;
  logic [DATA_W-1:0] c1_dout;
  logic              c1_ack;
  logic              c1_stall;

  // RAM side
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ack;

  modport slave (
    input  c0_cs, c0_we, c0_addr, c0_din,
    output c0_dout, c0_ack, c0_stall,
    input  c1_cs, c1_we, c1_addr, c1_din,
    output c1_dout, c1_ack, c1_stall,
    output mem_cs, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport master (
    output c0_cs, c0_we, c0_addr, c0_din,
    input  c0_dout, c0_ack, c0_stall,
    output c1_cs, c1_we, c1_addr, c1_din,
    input  c1_dout, c1_ack, c1_stall,
    input  mem_cs, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ack
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Two-port round-robin arbiter in front of a single multi-cycle RAM.   |
// | Latches the winning request, releases mem_cs in the ack cycle and    |
// | forces completion through a watchdog if the RAM never acknowledges.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  mem_arbiter_if.slave     bus,
  output logic             owner,
  output logic             err,
  output logic [1:0]       arb_state
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t        state;
  logic              last;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  logic              busy;
  logic              done;
  logic              wd_hit;
  logic              own_cs;
  logic              fire;
  logic              grant;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;

  // Busy is forced low while reset is asserted so every output is quiet.
  assign busy   = rst && (state == S_BUSY);
  assign done   = busy && bus.mem_ack;
  // A real ack in the last allowed cycle takes precedence over the watchdog.
  assign wd_hit = (TIMEOUT != 0) && busy && (cnt == CNT_LAST) && !bus.mem_ack;
  assign own_cs = owner ? bus.c1_cs : bus.c0_cs;
  // An owner that dropped cs (abort) gets no ack; the RAM access still runs out.
  assign fire   = (done || wd_hit) && own_cs;
  assign grant  = rr_pick(bus.c0_cs, bus.c1_cs, last);

  assign ack0  = fire && !owner;
  assign ack1  = fire &&  owner;
  // Watchdog completion returns zero data.
  assign rdata = done ? bus.mem_dout : '0;

  assign bus.c0_ack   = ack0;
  assign bus.c1_ack   = ack1;
  assign bus.c0_dout  = ack0 ? rdata : '0;
  assign bus.c1_dout  = ack1 ? rdata : '0;
  assign bus.c0_stall = bus.c0_cs && !ack0;
  assign bus.c1_stall = bus.c1_cs && !ack1;

  // cs drops combinationally in the ack (or watchdog) cycle so the RAM idles.
  assign bus.mem_cs   = busy && !bus.mem_ack && !wd_hit;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;

  assign arb_state = state;

  // Arbitration FSM: grant and latch in S_IDLE, wait for ack or timeout in S_BUSY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.c0_cs || bus.c1_cs) begin
            owner  <= grant;
            last   <= grant;
            we_q   <= grant ? bus.c1_we   : bus.c0_we;
            addr_q <= grant ? bus.c1_addr : bus.c0_addr;
            din_q  <= grant ? bus.c1_din  : bus.c0_din;
            cnt    <= '0;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_ack) begin
            state <= S_IDLE;
          end else if (wd_hit) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Self-checking bench: 4-cycle RAM model, scoreboard of expected acks, |
// | a vector table of transactions and cycle-accurate corner sequences.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       owner;
  logic       err;
  logic [1:0] arb_state;
  logic       hung = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .owner     (owner),
    .err       (err),
    .arb_state (arb_state)
  );

  // RAM model: acks one cycle after seeing cs for 4 cycles; writes echo din.
  logic [31:0] ram [0:63];
  int          ram_cnt = 0;

  always @(posedge clk) begin
    bus.mem_ack <= 1'b0;
    if (!rst) begin
      ram[4]  <= 32'hDEADBEEF;
      ram[16] <= 32'h0BADF00D;
    end
    if (bus.mem_cs && !hung) begin
      if (ram_cnt == 3) begin
        ram_cnt     <= 0;
        bus.mem_ack <= 1'b1;
        if (bus.mem_we) begin
          ram[bus.mem_addr[7:2]] <= bus.mem_din;
          bus.mem_dout           <= bus.mem_din;
        end else begin
          bus.mem_dout <= ram[bus.mem_addr[7:2]];
        end
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else begin
      ram_cnt <= 0;
    end
  end

  typedef struct packed {
    logic        port;
    logic [31:0] dout;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every requester ack must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.c0_ack || bus.c1_ack)) begin
      check("ack_exclusive", 64'(bus.c0_ack & bus.c1_ack), 64'd0);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got c0_ack=%0b c1_ack=%0b expected none", bus.c0_ack, bus.c1_ack);
      end else begin
        e = sbq.pop_front();
        check("sb_port", 64'(bus.c1_ack), 64'(e.port));
        check("sb_owner", 64'(owner), 64'(e.port));
        check("sb_dout", bus.c1_ack ? 64'(bus.c1_dout) : 64'(bus.c0_dout), 64'(e.dout));
        check("sb_other_dout", bus.c1_ack ? 64'(bus.c0_dout) : 64'(bus.c1_dout), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic port, input logic [31:0] d);
    exp_t e;
    e.port = port;
    e.dout = d;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic port, input logic cs, input logic we,
                       input logic [31:0] addr, input logic [31:0] din);
    if (port) begin
      bus.c1_cs = cs; bus.c1_we = we; bus.c1_addr = addr; bus.c1_din = din;
    end else begin
      bus.c0_cs = cs; bus.c0_we = we; bus.c0_addr = addr; bus.c0_din = din;
    end
  endtask

  // One transaction from an idle arbiter; returns with cs dropped, arbiter idle.
  task automatic run_txn(input vec_t v);
    int lat;
    lat = -1;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    push_exp(v.port, v.exp);
    for (int k = 0; k < 40; k++) begin
      sample();
      if (v.port ? bus.c1_ack : bus.c0_ack) begin
        lat = k;
        break;
      end
      step();
    end
    check($sformatf("txn_latency p%0d a%0h", v.port, v.addr), 64'(lat), 64'd5);
    step();
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h00, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[1] = '{1'b1, 1'b1, 32'h04, 32'h5A5A5A5A, 32'h5A5A5A5A};
    vecs[2] = '{1'b1, 1'b0, 32'h00, 32'h0,        32'hA5A5A5A5};
    vecs[3] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'h5A5A5A5A};
    vecs[4] = '{1'b0, 1'b1, 32'hFC, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 1'b0, 32'hFC, 32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    rst = 1'b0;
    step(); step();
    sample();
    check("rst_mem_cs", 64'(bus.mem_cs), 64'd0);
    check("rst_c0_ack", 64'(bus.c0_ack), 64'd0);
    check("rst_c1_ack", 64'(bus.c1_ack), 64'd0);
    check("rst_c0_dout", 64'(bus.c0_dout), 64'd0);
    check("rst_c1_dout", 64'(bus.c1_dout), 64'd0);
    step();
    rst = 1'b1;
    sample();
    check("rst_state", 64'(arb_state), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    step();

    // Single read with cycle-accurate timing
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    push_exp(1'b0, 32'hDEADBEEF);
    for (int k = 0; k <= 5; k++) begin
      sample();
      check($sformatf("rd_mem_cs c%0d", k), 64'(bus.mem_cs), 64'((k >= 1) && (k <= 4)));
      check($sformatf("rd_c0_ack c%0d", k), 64'(bus.c0_ack), 64'(k == 5));
      check($sformatf("rd_c0_stall c%0d", k), 64'(bus.c0_stall), 64'(k <= 4));
      if (k == 2) begin
        check("rd_owner", 64'(owner), 64'd0);
        check("rd_state", 64'(arb_state), 64'd1);
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Port 1 write then back-to-back read
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    push_exp(1'b1, 32'h12345678);
    for (int k = 0; k <= 11; k++) begin
      if (k == 6) begin
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        push_exp(1'b1, 32'h12345678);
      end
      sample();
      check($sformatf("wr_c1_ack c%0d", k), 64'(bus.c1_ack), 64'((k == 5) || (k == 11)));
      if ((k == 5) || (k == 6)) check($sformatf("wr_gap_mem_cs c%0d", k), 64'(bus.mem_cs), 64'd0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wr_ram_word", 64'(ram[8]), 64'h12345678);
    step();

    // Vector table
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
    end
    step();

    // Contention: both held from cycle 0, fresh reset so port 0 wins first
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) push_exp(1'(i % 2), (i % 2) ? 32'h12345678 : 32'hDEADBEEF);
    for (int k = 0; k <= 23; k++) begin
      sample();
      check($sformatf("rr_c0_ack c%0d", k), 64'(bus.c0_ack), 64'((k % 6 == 5) && ((k / 6) % 2 == 0)));
      check($sformatf("rr_c1_ack c%0d", k), 64'(bus.c1_ack), 64'((k % 6 == 5) && ((k / 6) % 2 == 1)));
      if ((k % 6 == 0) && (k > 0)) check($sformatf("rr_gap c%0d", k), 64'(bus.mem_cs), 64'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Latch check: requester changes after grant are ignored
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    push_exp(1'b0, 32'h0BADF00D);
    for (int k = 0; k <= 5; k++) begin
      if (k == 2) drive(1'b0, 1'b1, 1'b1, 32'h80, 32'hFFFF0000);
      sample();
      if ((k >= 1) && (k <= 4)) begin
        check($sformatf("latch_addr c%0d", k), 64'(bus.mem_addr), 64'h40);
        check($sformatf("latch_we c%0d", k), 64'(bus.mem_we), 64'd0);
      end
      check($sformatf("latch_ack c%0d", k), 64'(bus.c0_ack), 64'(k == 5));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Abort: port 0 drops cs mid-write, port 1 queued behind it
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    for (int k = 0; k <= 11; k++) begin
      if (k == 3) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        push_exp(1'b1, 32'hCAFEF00D);
      end
      sample();
      check($sformatf("abort_c0_ack c%0d", k), 64'(bus.c0_ack), 64'd0);
      check($sformatf("abort_c1_ack c%0d", k), 64'(bus.c1_ack), 64'(k == 11));
      if (k == 6) check("abort_gap_mem_cs", 64'(bus.mem_cs), 64'd0);
      if (k == 7) begin
        check("abort_c1_mem_cs", 64'(bus.mem_cs), 64'd1);
        check("abort_c1_owner", 64'(owner), 64'd1);
      end
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("abort_ram_word", 64'(ram[12]), 64'hCAFEF00D);
    step();

    // Watchdog: RAM never acks
    hung = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    push_exp(1'b0, 32'h0);
    for (int k = 0; k <= 9; k++) begin
      if (k == 9) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample();
      check($sformatf("wd_c0_ack c%0d", k), 64'(bus.c0_ack), 64'(k == 8));
      check($sformatf("wd_mem_cs c%0d", k), 64'(bus.mem_cs), 64'((k >= 1) && (k <= 7)));
      check($sformatf("wd_err c%0d", k), 64'(err), 64'(k >= 9));
      step();
    end
    repeat (3) step();
    sample();
    check("wd_err_sticky", 64'(err), 64'd1);
    hung = 1'b0;
    step();
    rst = 1'b0;
    sample();
    check("wd_rst_mem_cs", 64'(bus.mem_cs), 64'd0);
    step();
    rst = 1'b1;
    sample();
    check("wd_rst_err", 64'(err), 64'd0);
    check("wd_rst_state", 64'(arb_state), 64'd0);
    step();

    // Reset asserted mid-transaction
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    step();
    sample();
    check("midrst_busy", 64'(arb_state), 64'd1);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("midrst_mem_cs", 64'(bus.mem_cs), 64'd0);
    check("midrst_c1_ack", 64'(bus.c1_ack), 64'd0);
    step();
    rst = 1'b1;
    sample();
    check("midrst_state", 64'(arb_state), 64'd0);
    check("midrst_mem_cs_after", 64'(bus.mem_cs), 64'd0);
    repeat (8) step();

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port round-robin arbiter that shares the single multi-cycle data RAM between two requesters, e.g. the I-cache refill port (port 0) and the D-cache refill/write-back port (port 1).
- Requester side keeps the RAM's own handshake (cs/we/addr/din in; dout/ack/stall out), so either requester can connect directly to the RAM or through this block.
- Adds request latching, fairness, clean cs release between transactions, and a watchdog against a hung memory.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- TIMEOUT, 64, max cycles in S_BUSY without mem_ack before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- c0_cs  in  1  port 0 request; held until c0_ack.
- c0_we  in  1  port 0 write enable.
- c0_addr  in  ADDR_W  port 0 byte address.
- c0_din  in  DATA_W  port 0 write data.
- c0_dout  out  DATA_W  port 0 read data; valid only while c0_ack=1.
- c0_ack  out  1  port 0 completion pulse.
- c0_stall  out  1  c0_cs & ~c0_ack.
- c1_cs, c1_we, c1_addr, c1_din, c1_dout, c1_ack, c1_stall: same as port 0, for port 1.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data.
- mem_ack  in  1  RAM completion, one-cycle pulse.
- owner  out  1  port currently granted; meaningful in S_BUSY.
- err  out  1  sticky watchdog flag.
- arb_state  out  2  current FSM state, for debug.

Behaviour:
- States: S_IDLE=0, S_BUSY=1; encodings 2 and 3 are unused and fall to S_IDLE.
- Reset (rst=0 at posedge):
  - state=S_IDLE, last=1 (port 0 wins first), err=0, counter=0, latched regs=0.
  - Outputs during reset: mem_cs=0, both acks=0, both douts=0.
- S_IDLE:
  - No cs high: stay.
  - One cs high: grant that port.
  - Both cs high: grant the port != last.
  - On grant, at the posedge register owner, last<=granted port, we/addr/din of the winner into mem_we/mem_addr/mem_din, counter<=0; go to S_BUSY.
- S_BUSY:
  - mem_cs = ~mem_ack, combinational, so cs is already low in the ack cycle and the RAM returns to idle.
  - mem_we/addr/din come from the latched registers; later requester changes are ignored.
  - Counter increments every cycle.
- Completion (mem_ack=1 in S_BUSY):
  - c{owner}_ack=1 and c{owner}_dout=mem_dout (mem_dout for writes too), same cycle, combinational.
  - Next state S_IDLE; the other port's ack=0.
- Latency with a 4-cycle RAM: cs rises at cycle 0 -> mem_cs at 1 -> mem_ack and c_ack at 5. Back-to-back grants have a 1-cycle S_IDLE gap with mem_cs=0.
- Abort: owner drops cs in S_BUSY.
  - The transaction runs to mem_ack and memory is still written if we=1.
  - c_ack is suppressed (ack = mem_ack & c{owner}_cs).
- Watchdog: counter==TIMEOUT-1 and no mem_ack.
  - mem_cs=0 that cycle; c{owner}_ack=1 with dout=0; err<=1; go to S_IDLE.
  - If mem_ack arrives in the same cycle, normal completion applies and err is unchanged.
  - Counter width is clog2(TIMEOUT)+1.
- Non-owner port: ack=0 and dout=0 always; its stall follows cs.
- Reset asserted mid-S_BUSY: S_IDLE next cycle, mem_cs=0. The RAM sees cs=0 and returns to idle.

Decomposition:
- Shared package holds the state encodings (S_IDLE, S_BUSY), the default TIMEOUT, and the ADDR_W/DATA_W defaults used by the cache, RAM and arbiter.
- No sub-module; the round-robin pick is a 2-input function inside the block.

Test Plan:
- Single read: c0_cs=1, we=0, addr=0x10, RAM word[4]=0xDEADBEEF -> mem_cs high cycles 1-4, c0_ack=1 at cycle 5 with c0_dout=0xDEADBEEF, c0_stall=1 cycles 0-4.
- Write then read: c1 writes 0x12345678 to 0x20, then reads 0x20 -> c1_ack pulses at cycles 5 and 11, readback 0x12345678; mem_cs=0 in cycles 5 and 6.
- Contention: c0_cs and c1_cs both high from cycle 0 and held -> order p0, p1, p0, p1; owner alternates; no cycle with both acks high.
- Latch check: c0 granted at addr 0x40, c0_addr changed to 0x80 at cycle 2 -> mem_addr stays 0x40 until ack.
- Abort: c0 drops cs at cycle 3 of a write -> no c0_ack; RAM word written; a c1 request queued at cycle 3 gets mem_cs at cycle 7.
- Watchdog and reset: TIMEOUT=8, mem_ack tied 0 -> c0_ack with dout=0 at cycle 8, err=1 sticky; rst=0 for one cycle -> err=0, arb_state=0, mem_cs=0.
